spi_frame_slave: RTL and testbench

Full-duplex SPI slave that moves one 256-bit frame per chip-select window between the Raspberry Pi (SPI master) and the FPGA. It sits between the RPi SPI pins and the frame pack/unpack mapping: it serialises the packed FPGA→RPI frame onto MISO and deserialises the RPI→FPGA frame from MOSI into a parallel word for the unpacker. SPI mode 0 (CPOL=0, CPHA=0), MSB first (bit 255 first). All SPI pins are oversampled in the CLK domain.

---
 rtl/spi_frame_slave.sv | 164 ++++++++++++++++
 tb/tb_spi_frame_slave.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_slave.sv
// Mode-0 SPI slave that exchanges one FRAME_BITS-wide frame per CS_N low window, with all pins oversampled on CLK.
// Define SPI_FRAME_MISO_TRISTATE_EN to release MISO (Z) outside a frame; otherwise MISO idles at 0.
module spi_frame_slave #(
    parameter int FRAME_BITS  = 256,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  SPI_SCLK,
    input  logic                  SPI_CS_N,
    input  logic                  SPI_MOSI,
    output logic                  SPI_MISO,
    input  logic [FRAME_BITS-1:0] TX_DATA,
    output logic [FRAME_BITS-1:0] RX_DATA,
    output logic                  TX_LOAD,
    output logic                  RX_VALID,
    output logic                  FRAME_ERR
);

    localparam int            CW       = $clog2(FRAME_BITS + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, warm_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   ovr_q, ovr_d;
    logic                   armed_q, armed_d;
    logic [FRAME_BITS-2:0]  tx_shift_q, tx_shift_d;
    logic [FRAME_BITS-1:0]  rx_shift_q, rx_shift_d;
    logic [FRAME_BITS-1:0]  rx_data_q, rx_data_d;
    logic                   miso_q, miso_d;
    logic                   tx_load_q, tx_load_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;

    // warm_q marks when the synchronisers hold real pin samples rather than reset values
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            warm_q      <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SPI_SCLK};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], SPI_CS_N};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
            warm_q      <= {warm_q[SYNC_STAGES-2:0], 1'b1};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ovr_q       <= 1'b0;
            armed_q     <= 1'b0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            miso_q      <= 1'b0;
            tx_load_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ovr_q       <= ovr_d;
            armed_q     <= armed_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            miso_q      <= miso_d;
            tx_load_q   <= tx_load_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ovr_d       = ovr_q;
        armed_d     = armed_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        miso_d      = miso_q;
        tx_load_d   = 1'b0;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (warm_q[SYNC_STAGES-1] && cs_s) begin
                    armed_d = 1'b1;
                end
                if (cs_fall && armed_q) begin
                    state_d    = SHIFT;
                    armed_d    = 1'b0;
                    tx_shift_d = TX_DATA[FRAME_BITS-2:0];
                    miso_d     = TX_DATA[FRAME_BITS-1];
                    cnt_d      = '0;
                    ovr_d      = 1'b0;
                    tx_load_d  = 1'b1;
                end
            end
            SHIFT: begin
                // CS_N edges win over any SCLK edge seen in the same cycle
                if (cs_rise) begin
                    state_d = IDLE;
                    miso_d  = 1'b0;
                    if (cnt_q == CNT_FULL && !ovr_q) begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[FRAME_BITS-2:0], mosi_s};
                    if (cnt_q == CNT_FULL) begin
                        ovr_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (sclk_fall && cnt_q != '0 && cnt_q != CNT_FULL) begin
                    miso_d     = tx_shift_q[FRAME_BITS-2];
                    tx_shift_d = {tx_shift_q[FRAME_BITS-3:0], 1'b0};
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SPI_FRAME_MISO_TRISTATE_EN
    assign SPI_MISO = (state_q == SHIFT) ? miso_q : 1'bz;
`else
    assign SPI_MISO = miso_q;
`endif

    assign RX_DATA   = rx_data_q;
    assign TX_LOAD   = tx_load_q;
    assign RX_VALID  = rx_valid_q;
    assign FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_spi_frame_slave.sv
// Directed bench for spi_frame_slave: CLK 50 MHz, SCLK 5 MHz, mode-0 master model.
module tb_spi_frame_slave;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         SPI_SCLK;
    logic         SPI_CS_N;
    logic         SPI_MOSI;
    logic         SPI_MISO;
    logic [255:0] TX_DATA;
    logic [255:0] RX_DATA;
    logic         TX_LOAD;
    logic         RX_VALID;
    logic         FRAME_ERR;

    spi_frame_slave #(.FRAME_BITS(256), .SYNC_STAGES(2)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .SPI_SCLK  (SPI_SCLK),
        .SPI_CS_N  (SPI_CS_N),
        .SPI_MOSI  (SPI_MOSI),
        .SPI_MISO  (SPI_MISO),
        .TX_DATA   (TX_DATA),
        .RX_DATA   (RX_DATA),
        .TX_LOAD   (TX_LOAD),
        .RX_VALID  (RX_VALID),
        .FRAME_ERR (FRAME_ERR)
    );

    always #10 CLK = ~CLK;

`ifdef SPI_FRAME_MISO_TRISTATE_EN
    localparam logic MISO_IDLE = 1'bz;
`else
    localparam logic MISO_IDLE = 1'b0;
`endif

    int cyc = 0;
    int n_load = 0, n_rv = 0, n_fe = 0;
    int load_cyc = 0, rv_cyc = 0;
    int cs_fall_cyc = 0, cs_rise_cyc = 0;
    logic [255:0] rx_last = '0, rx_prev = '0;
    int total = 0, passed = 0;

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        if (TX_LOAD === 1'b1) begin
            n_load++;
            load_cyc = cyc;
        end
        if (RX_VALID === 1'b1) begin
            n_rv++;
            rv_cyc  = cyc;
            rx_prev = rx_last;
            rx_last = RX_DATA;
        end
        if (FRAME_ERR === 1'b1) n_fe++;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Master: nbits SCLK cycles, optional TX_DATA change before bit chg_at, optional CS_N release.
    task automatic spi_xfer(input logic [255:0] mosi_w, input int nbits, input bit raise_cs,
                            input int chg_at, input logic [255:0] tx_new,
                            output logic [255:0] miso_w, output logic last_bit);
        miso_w   = '0;
        last_bit = 1'b0;
        SPI_CS_N = 1'b0;
        cs_fall_cyc = cyc;
        repeat (6) @(negedge CLK);
        for (int i = 0; i < nbits; i++) begin
            if (i == chg_at) TX_DATA = tx_new;
            SPI_MOSI = (i < 256) ? mosi_w[255-i] : 1'b0;
            repeat (5) @(negedge CLK);
            SPI_SCLK = 1'b1;
            last_bit = SPI_MISO;
            if (i < 256) miso_w[255-i] = SPI_MISO;
            repeat (5) @(negedge CLK);
            SPI_SCLK = 1'b0;
        end
        if (raise_cs) begin
            repeat (5) @(negedge CLK);
            SPI_CS_N = 1'b1;
            cs_rise_cyc = cyc;
        end
    endtask

    initial begin
        logic [255:0] tx_pat, mosi_nom, w1, w2, ones, got;
        logic         lb;
        int           b_load, b_rv, b_fe;

        tx_pat   = {16{16'hA5C3}};
        mosi_nom = {4{64'h0123456789ABCDEF}};
        w1       = {4{64'hDEADBEEFCAFEF00D}};
        w2       = ~w1;
        ones     = '1;

        RESET = 1'b1; SPI_SCLK = 1'b0; SPI_CS_N = 1'b1; SPI_MOSI = 1'b0; TX_DATA = tx_pat;
        repeat (3) @(negedge CLK);
        chk("reset_miso", 256'(SPI_MISO), 256'(MISO_IDLE));
        chk("reset_rx_data", RX_DATA, '0);
        chk("reset_tx_load", 256'(TX_LOAD), '0);
        chk("reset_rx_valid", 256'(RX_VALID), '0);
        chk("reset_frame_err", 256'(FRAME_ERR), '0);
        RESET = 1'b0;
        repeat (10) @(negedge CLK);

        // Nominal frame
        b_load = n_load; b_rv = n_rv; b_fe = n_fe;
        spi_xfer(mosi_nom, 256, 1'b1, -1, '0, got, lb);
        repeat (10) @(negedge CLK);
        chk("nom_miso_word", got, tx_pat);
        chk("nom_rx_data", RX_DATA, mosi_nom);
        chk("nom_rx_at_valid", rx_last, mosi_nom);
        chk("nom_tx_load_cnt", 256'(n_load - b_load), 256'd1);
        chk("nom_rx_valid_cnt", 256'(n_rv - b_rv), 256'd1);
        chk("nom_frame_err_cnt", 256'(n_fe - b_fe), 256'd0);
        chk("nom_tx_load_lat", 256'(load_cyc - cs_fall_cyc), 256'd3);
        chk("nom_rx_valid_lat", 256'(rv_cyc - cs_rise_cyc), 256'd3);
        chk("nom_miso_idle", 256'(SPI_MISO), 256'(MISO_IDLE));

        // Short frame: 100 bits
        b_rv = n_rv; b_fe = n_fe;
        spi_xfer(w1, 100, 1'b1, -1, '0, got, lb);
        repeat (10) @(negedge CLK);
        chk("short_frame_err_cnt", 256'(n_fe - b_fe), 256'd1);
        chk("short_rx_valid_cnt", 256'(n_rv - b_rv), 256'd0);
        chk("short_rx_data_held", RX_DATA, mosi_nom);

        // Long frame: 257 bits, MISO must hold bit 0 on the extra clock
        b_rv = n_rv; b_fe = n_fe;
        spi_xfer(w2, 257, 1'b1, -1, '0, got, lb);
        repeat (10) @(negedge CLK);
        chk("long_frame_err_cnt", 256'(n_fe - b_fe), 256'd1);
        chk("long_rx_valid_cnt", 256'(n_rv - b_rv), 256'd0);
        chk("long_rx_data_held", RX_DATA, mosi_nom);
        chk("long_miso_word", got, tx_pat);
        chk("long_miso_frozen", 256'(lb), 256'd1);

        // Snapshot: TX_DATA drops to 0 after bit 10
        TX_DATA = ones;
        repeat (4) @(negedge CLK);
        b_rv = n_rv;
        spi_xfer(w1, 256, 1'b1, 11, '0, got, lb);
        repeat (10) @(negedge CLK);
        chk("snap_miso_word", got, ones);
        chk("snap_rx_data", RX_DATA, w1);
        chk("snap_rx_valid_cnt", 256'(n_rv - b_rv), 256'd1);

        // Reset after 50 bits with CS_N held low
        TX_DATA = tx_pat;
        b_load = n_load; b_rv = n_rv; b_fe = n_fe;
        spi_xfer(w2, 50, 1'b0, -1, '0, got, lb);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        chk("rst_mid_miso", 256'(SPI_MISO), 256'(MISO_IDLE));
        chk("rst_mid_rx_data", RX_DATA, '0);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        b_load = n_load;
        repeat (20) @(negedge CLK);
        chk("rst_mid_no_tx_load", 256'(n_load - b_load), 256'd0);
        chk("rst_mid_no_rx_valid", 256'(n_rv - b_rv), 256'd0);
        chk("rst_mid_no_frame_err", 256'(n_fe - b_fe), 256'd0);
        SPI_CS_N = 1'b1;
        repeat (10) @(negedge CLK);
        spi_xfer(w2, 256, 1'b1, -1, '0, got, lb);
        repeat (10) @(negedge CLK);
        chk("rst_next_tx_load_cnt", 256'(n_load - b_load), 256'd1);
        chk("rst_next_rx_valid_cnt", 256'(n_rv - b_rv), 256'd1);
        chk("rst_next_rx_data", RX_DATA, w2);
        chk("rst_next_miso_word", got, tx_pat);

        // Back-to-back frames, CS_N high for 3 CLK between them
        b_rv = n_rv; b_fe = n_fe;
        spi_xfer(w1, 256, 1'b1, -1, '0, got, lb);
        repeat (3) @(negedge CLK);
        spi_xfer(mosi_nom, 256, 1'b1, -1, '0, got, lb);
        repeat (10) @(negedge CLK);
        chk("b2b_rx_valid_cnt", 256'(n_rv - b_rv), 256'd2);
        chk("b2b_frame_err_cnt", 256'(n_fe - b_fe), 256'd0);
        chk("b2b_first_word", rx_prev, w1);
        chk("b2b_second_word", rx_last, mosi_nom);
        chk("b2b_miso_word", got, tx_pat);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
